gaussian_smooth: RTL and testbench

- 3x3 Gaussian smoothing stage placed directly upstream of the Sobel/NMS/hysteresis edge stage in the Canny pipeline.
- Consumes an 8-bit raster pixel stream (IMG_WIDTH x IMG_HEIGHT).
- Produces a smoothed stream of identical size and raster order, so the edge stage sees reduced noise.
- Uses line buffers, border replication and an end-of-frame flush.

---
 rtl/fifa_img_pkg.sv | 32 +++
 rtl/gaussian_smooth_if.sv | 27 ++
 rtl/gauss_line_buffer.sv | 36 +++
 rtl/gaussian_smooth.sv | 154 +++++++++++++++
 tb/tb_gaussian_smooth.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifa_img_pkg.sv
// Shared types, frame defaults and kernel constants for the Gaussian smoothing stage.
// The 3x3 kernel [1 2 1; 2 4 2; 1 2 1] is applied separably: a vertical 1-2-1 column
// sum followed by a horizontal 1-2-1 sum of three column sums.
package fifa_img_pkg;

  localparam int DEFAULT_IMG_WIDTH  = 128;
  localparam int DEFAULT_IMG_HEIGHT = 128;

  typedef logic [7:0]  pixel_t;
  typedef logic [11:0] gsum_t;
  // One vertical 3-tap column sum, max 4*255 = 1020
  typedef logic [9:0]  csum_t;

  // 1-D taps of the separable kernel (outer product gives the 3x3 weights)
  localparam int    GAUSS_K_SIDE = 1;
  localparam int    GAUSS_K_MID  = 2;
  localparam int    GAUSS_SHIFT  = 4;
  localparam gsum_t GAUSS_ROUND  = 12'd8;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} gauss_state_t;

  function automatic csum_t tap3(pixel_t a, pixel_t b, pixel_t c);
    return csum_t'(a) * csum_t'(GAUSS_K_SIDE) + csum_t'(b) * csum_t'(GAUSS_K_MID)
         + csum_t'(c) * csum_t'(GAUSS_K_SIDE);
  endfunction

  function automatic gsum_t hsum(csum_t a, csum_t b, csum_t c);
    return gsum_t'(a) * gsum_t'(GAUSS_K_SIDE) + gsum_t'(b) * gsum_t'(GAUSS_K_MID)
         + gsum_t'(c) * gsum_t'(GAUSS_K_SIDE);
  endfunction

endpackage

// File: rtl/gaussian_smooth_if.sv
// Pixel stream bundle for gaussian_smooth: input beat handshake plus output strobe.
// Optional macro GAUSS_BYPASS_EN adds the per-beat bypass request.
interface gaussian_smooth_if;
  import fifa_img_pkg::*;

  pixel_t in_pixel;
  logic   in_valid;
  logic   in_sof;
  logic   in_ready;
  pixel_t out_pixel;
  logic   out_valid;
  logic   out_sof;

`ifdef GAUSS_BYPASS_EN
  logic   bypass;

  modport slave  (input  in_pixel, in_valid, in_sof, bypass,
                  output in_ready, out_pixel, out_valid, out_sof);
  modport master (output in_pixel, in_valid, in_sof, bypass,
                  input  in_ready, out_pixel, out_valid, out_sof);
`else
  modport slave  (input  in_pixel, in_valid, in_sof,
                  output in_ready, out_pixel, out_valid, out_sof);
  modport master (output in_pixel, in_valid, in_sof,
                  input  in_ready, out_pixel, out_valid, out_sof);
`endif
endinterface

// File: rtl/gauss_line_buffer.sv
// Two line memories sharing one column pointer. tap1 is the pixel one line above
// the current beat, tap2 two lines above. Reads are registered, so the caller
// presents the column of the *next* beat on rd_addr to have its taps ready.
module gauss_line_buffer
  import fifa_img_pkg::*;
#(
  parameter int DEPTH = DEFAULT_IMG_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr,
  input  pixel_t        din,
  output pixel_t        tap1,
  output pixel_t        tap2
);

  pixel_t line1 [DEPTH];
  pixel_t line2 [DEPTH];

  // store the new pixel and age the previous line1 content into line2
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line1[wr_addr] <= din;
      line2[wr_addr] <= tap1;
    end
  end

  // registered read of the prefetched column
  always_ff @(posedge clk) begin
    tap1 <= line1[rd_addr];
    tap2 <= line2[rd_addr];
  end

endmodule

// File: rtl/gaussian_smooth.sv
// 3x3 Gaussian smoothing with edge replication and end-of-frame flush.
// Output k is emitted one cycle after the beat carrying input k+W+1; the last
// W+1 outputs come from internal FLUSH beats that replicate the bottom row.
// Optional macro GAUSS_BYPASS_EN: a beat with bypass high emits the centre tap.
module gaussian_smooth
  import fifa_img_pkg::*;
#(
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
  input logic              clk,
  input logic              rst,
  gaussian_smooth_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  gauss_state_t  state, state_next;
  logic [CW-1:0] col, col_next, pos_col, col_fetch;
  logic [RW-1:0] row, row_next, pos_row;
  logic          ready, accept, sof_beat, adv, emit, wr_en, first;
  logic [AW-1:0] rd_addr;
  pixel_t        tap1, tap2, top, bot, filt, result;
  csum_t         v_sum, p1_sum, p2_sum, left, right;
  gsum_t         sum;

  gauss_line_buffer #(.DEPTH(IMG_WIDTH)) u_lines (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(pos_col[AW-1:0]),
    .rd_addr(rd_addr),
    .din    (bus.in_pixel),
    .tap1   (tap1),
    .tap2   (tap2)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state: sof always restarts the frame, last input enters the flush
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (sof_beat) state_next = FILL;
      FILL:  if (sof_beat) state_next = FILL;
             else if (accept && pos_row == RW'(1) && pos_col == '0) state_next = RUN;
      RUN:   if (sof_beat) state_next = FILL;
             else if (accept && pos_row == ROW_LAST && pos_col == COL_LAST) state_next = FLUSH;
      FLUSH: if (col == COL_END) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake, internal beat advance and output strobe
  always_comb begin
    ready    = (state != FLUSH);
    accept   = bus.in_valid && ready;
    sof_beat = accept && bus.in_sof;
    adv      = 1'b0;
    emit     = 1'b0;
    case (state)
      IDLE:  adv = sof_beat;
      FILL:  adv = accept;
      RUN:   begin adv = accept; emit = accept && !bus.in_sof; end
      FLUSH: begin adv = 1'b1;   emit = 1'b1; end
      default: ;
    endcase
    wr_en = adv && (state != FLUSH);
    first = (state == RUN) && pos_row == RW'(1) && pos_col == CW'(1);
  end

  assign bus.in_ready = ready;

  // beat position, next position and line-buffer prefetch address
  always_comb begin
    pos_col = sof_beat ? '0 : col;
    pos_row = sof_beat ? '0 : row;
    if (state == FLUSH) begin
      col_next = (col == COL_END) ? '0 : col + CW'(1);
      row_next = (col == COL_END) ? '0 : row;
    end else if (pos_col == COL_LAST) begin
      col_next = '0;
      row_next = pos_row + RW'(1);
    end else begin
      col_next = pos_col + CW'(1);
      row_next = pos_row;
    end
    // column W only exists during flush and never uses its fetched taps
    col_fetch = adv ? col_next : col;
    rd_addr   = (col_fetch == COL_END) ? '0 : col_fetch[AW-1:0];
  end

  // window: p1 is the centre column, p2 the left; clamp at all four borders
  always_comb begin
    top   = (pos_row == RW'(1)) ? tap1 : tap2;
    bot   = (state == FLUSH) ? tap1 : bus.in_pixel;
    v_sum = tap3(top, tap1, bot);
    left  = (pos_col == CW'(1)) ? p1_sum : p2_sum;
    right = (pos_col == '0 || pos_col == COL_END) ? p1_sum : v_sum;
    sum   = hsum(left, p1_sum, right);
    filt  = pixel_t'((sum + GAUSS_ROUND) >> GAUSS_SHIFT);
  end

`ifdef GAUSS_BYPASS_EN
  pixel_t p1_mid;

  // centre pixel travels alongside the centre column sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      p1_mid <= '0;
    else if (adv) p1_mid <= tap1;
  end

  assign result = (bus.bypass && state != FLUSH) ? p1_mid : filt;
`else
  assign result = filt;
`endif

  // frame counters and horizontal window shift advance on every internal beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      p1_sum <= '0;
      p2_sum <= '0;
    end else if (adv) begin
      col    <= col_next;
      row    <= row_next;
      p1_sum <= v_sum;
      p2_sum <= p1_sum;
    end
  end

  // registered output strobe, one cycle after the triggering beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_pixel <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
    end else begin
      bus.out_valid <= emit;
      bus.out_sof   <= emit && first;
      if (emit) bus.out_pixel <= result;
    end
  end

endmodule

// File: tb/tb_gaussian_smooth.sv
// Self-checking bench for gaussian_smooth: random frames checked against a direct
// clamped 2-D convolution of the stored frame.
module tb_gaussian_smooth;

  localparam int W = 16;
  localparam int H = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gaussian_smooth_if bus();

  gaussian_smooth #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int img [H][W];
  int out_q [$];
  int sof_q [$];
  int ref_q [$];
  int exp_a [$];
  int rdy_low = 0;
  int n_acc = 0;
  int first_acc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // capture outputs and handshake away from the active edge
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (out_q.size() == 0) first_acc = n_acc;
      out_q.push_back(int'(bus.out_pixel));
      sof_q.push_back(int'(bus.out_sof));
    end
    if (bus.in_ready !== 1'b1) rdy_low++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int model(int r, int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr;
        int cc;
        rr = (r + dr < 0) ? 0 : ((r + dr > H - 1) ? H - 1 : r + dr);
        cc = (c + dc < 0) ? 0 : ((c + dc > W - 1) ? W - 1 : c + dc);
        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[rr][cc];
      end
    end
    return (s + 8) / 16;
  endfunction

  // kind 0: constant val, 1: impulse val at (pr,pc), 2: random
  task automatic fill(input int kind, input int val, input int pr, input int pc);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = val;
          1:       img[r][c] = (r == pr && c == pc) ? val : 0;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic clear_capture();
    out_q.delete();
    sof_q.delete();
    rdy_low   = 0;
    n_acc     = 0;
    first_acc = -1;
  endtask

  task automatic drive_beat(input int pix, input bit sof);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = pix[7:0];
    bus.in_sof   = sof;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    n_acc++;
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send(input int n, input int gap_pct, input bit with_sof);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
        repeat (int'($urandom_range(3, 1))) @(negedge clk);
      drive_beat(img[i / W][i % W], with_sof && i == 0);
    end
  endtask

  task automatic wait_out(input string tag, input int n);
    int cyc = 0;
    while (out_q.size() < n && cyc < 4 * W * H + 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (W + 8) @(negedge clk);
    check({tag, "_count"}, out_q.size(), n);
  endtask

  task automatic compare_frame(input string tag, input int base);
    for (int k = 0; k < W * H; k++) begin
      if (base + k < out_q.size()) begin
        check($sformatf("%s_pix_r%0d_c%0d", tag, k / W, k % W), out_q[base + k], model(k / W, k % W));
        check($sformatf("%s_sof_k%0d", tag, k), sof_q[base + k], (k == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int na;
    int sofs;
    int cyc;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
`ifdef GAUSS_BYPASS_EN
    bus.bypass   = 1'b0;
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_out_pixel", bus.out_pixel, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // constant frame, continuous valid
    fill(0, 100, 0, 0);
    clear_capture();
    send(W * H, 0, 1'b1);
    wait_out("const", W * H);
    check("const_ready_low", rdy_low, W + 1);
    check("const_first_latency", first_acc, W + 2);
    compare_frame("const", 0);

    // impulse 160 at (5,5)
    fill(1, 160, 5, 5);
    clear_capture();
    send(W * H, 0, 1'b1);
    wait_out("imp160", W * H);
    check("imp160_r5c5", out_q[5 * W + 5], 40);
    check("imp160_r5c4", out_q[5 * W + 4], 20);
    check("imp160_r4c4", out_q[4 * W + 4], 10);
    compare_frame("imp160", 0);

    // impulse 255 at the corner
    fill(1, 255, 0, 0);
    clear_capture();
    send(W * H, 0, 1'b1);
    wait_out("imp255", W * H);
    check("imp255_r0c0", out_q[0], 143);
    check("imp255_r0c1", out_q[1], 48);
    compare_frame("imp255", 0);

    // random frame gap-free, then again with random input gaps
    fill(2, 0, 0, 0);
    clear_capture();
    send(W * H, 0, 1'b1);
    wait_out("rnd", W * H);
    compare_frame("rnd", 0);
    ref_q = out_q;
    clear_capture();
    send(W * H, 30, 1'b1);
    wait_out("gap", W * H);
    check("gap_first_latency", first_acc, W + 2);
    for (int k = 0; k < W * H && k < out_q.size() && k < ref_q.size(); k++)
      check($sformatf("gap_vs_nogap_k%0d", k), out_q[k], ref_q[k]);
    compare_frame("gap", 0);

    // sof reasserted at input index 300 truncates the frame
    na = 300 - W - 1;
    fill(2, 0, 0, 0);
    exp_a.delete();
    for (int k = 0; k < na; k++) exp_a.push_back(model(k / W, k % W));
    clear_capture();
    send(300, 0, 1'b1);
    fill(2, 0, 0, 0);
    send(W * H, 0, 1'b1);
    wait_out("abort", na + W * H);
    for (int k = 0; k < na && k < out_q.size(); k++)
      check($sformatf("abort_old_k%0d", k), out_q[k], exp_a[k]);
    check("abort_old_sof", (sof_q.size() > 0) ? sof_q[0] : 0, 1);
    sofs = 0;
    foreach (sof_q[i]) sofs += sof_q[i];
    check("abort_sof_total", sofs, 2);
    compare_frame("abort_new", na);

    // reset pulsed during flush
    fill(2, 0, 0, 0);
    clear_capture();
    send(W * H, 0, 1'b1);
    cyc = 0;
    while (bus.in_ready === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    check("flush_out_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstflush_out_valid", bus.out_valid, 0);
    check("rstflush_out_sof", bus.out_sof, 0);
    check("rstflush_out_pixel", bus.out_pixel, 0);
    check("rstflush_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_capture();
    send(40, 0, 1'b0);
    repeat (10) @(negedge clk);
    check("nosof_dropped", out_q.size(), 0);
    fill(2, 0, 0, 0);
    clear_capture();
    send(W * H, 0, 1'b1);
    wait_out("post_rst", W * H);
    compare_frame("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
